instr_encoder: RTL and testbench
================================

Name: instr_encoder

Overview:
- Inverse of control_unit: packs mnemonic ID plus register/immediate fields into 32-bit ISA words (OP = bits 31:26, VEC = bit 0) and streams them, with sequential addresses, to the instruction-memory loader.
- Used by the program loader and by self-checking benches to generate instruction streams.
- Valid/ready handshake on both sides; one output register stage; appends a NOP terminator at end of program.

Parameters:
ADDR_W, 10, width of MEM_ADDR; address wraps modulo 2^ADDR_W
BASE_ADDR, 0, address loaded on START

Ports:
CLK  input  1  clock, rising edge
RST  input  1  asynchronous active-high reset
START  input  1  pulse: clear counter and errors, begin program
FINISH  input  1  pulse: end program, emit terminator NOP
IN_VALID  input  1  field bundle valid
IN_READY  output  1  encoder accepts bundle this cycle
MNEM  input  5  mnemonic ID (encoding below)
RS  input  5  source register 1
RT  input  5  source register 2 / I-type destination
RD  input  5  R-type destination
IMM  input  26  immediate (I-type uses [15:0]), jump target (J uses [25:0])
OUT_VALID  output  1  MEM_WDATA/MEM_ADDR valid
OUT_READY  input  1  consumer accepts word
MEM_WDATA  output  32  encoded instruction
MEM_ADDR  output  ADDR_W  word address of MEM_WDATA
COUNT  output  ADDR_W+1  words emitted since START, including terminator
ERR_ILLEGAL  output  1  sticky: illegal MNEM seen
DONE  output  1  terminator consumed, encoder idle

Behaviour:
- MNEM -> opcode/format/VEC:
  - 0 ADD 000000 R,0; 1 ADDI 000001 I; 2 ADDV 000000 R,1
  - 3 SUB 000010 R,0; 4 SUBI 000011 I; 5 SUBV 000010 R,1
  - 6 XOR 000100 R,0; 7 XORI 000101 I; 8 XORV 000100 R,1; 9 MULT 000110 R,0
  - 10 SLV 000111 I; 11 SRV 001000 I; 12 SCLV 001001 I; 13 SCRV 001010 I
  - 14 LW 001011 I; 15 SW 001100 I; 16 J 001101 J; 17 BEQ 010000 I; 18 NOP 111111 N
  - 19..31 illegal
- Word formats:
  - R: {op, RS, RT, RD, 10'b0, VEC}
  - I: {op, RS, RT, IMM[15:0]}
  - J: {op, IMM[25:0]}
  - N: {op, 26'b0} = 0xFC000000
  - Unused input fields ignored.
- FSM states IDLE, RUN, TERM, DRAIN, DONE_ST; reset enters IDLE.
- Reset (async):
  - OUT_VALID=0, MEM_WDATA=0, MEM_ADDR=BASE_ADDR, COUNT=0, ERR_ILLEGAL=0, DONE=0.
  - Any in-flight word is discarded.
- Input handshake: IN_READY = (state==RUN) && !FINISH && (!OUT_VALID || OUT_READY). Transfer occurs when IN_VALID && IN_READY.
- Legal transfer:
  - Word loads the output register next edge (latency 1); OUT_VALID=1.
  - MEM_ADDR is the address of the next unused slot.
- Illegal transfer:
  - Bundle consumed; ERR_ILLEGAL set.
  - Output register not loaded (OUT_VALID falls if it was being consumed); address not advanced.
- Output handshake (OUT_VALID && OUT_READY):
  - COUNT+1; address for next word = MEM_ADDR+1 mod 2^ADDR_W.
  - Back-to-back transfers allowed: full throughput, one word/cycle.
- OUT_VALID && !OUT_READY: MEM_WDATA/MEM_ADDR held stable; IN_READY=0.
- State transitions:
  - IDLE: IN_READY=0. START -> RUN, address=BASE_ADDR, COUNT=0, ERR_ILLEGAL=0.
  - RUN: FINISH -> TERM; no bundle accepted that cycle.
  - TERM: when output register free (empty or handshaking this cycle), load NOP at next address -> DRAIN.
  - DRAIN: terminator handshake -> DONE_ST.
  - DONE_ST: DONE=1, IN_READY=0. START -> RUN (fresh program, DONE falls).
- START outside IDLE/DONE_ST and FINISH outside RUN are ignored.
- COUNT saturates at 2^ADDR_W; the address still wraps.

Test Plan:
- START; MNEM=0 (ADD), RS=1, RT=2, RD=3, OUT_READY=1 -> next cycle OUT_VALID=1, MEM_WDATA=0x00221800, MEM_ADDR=0, COUNT becomes 1.
- Stream ADDI(1,2,imm 10), ADDV(1,2,4), SW(1,2,10), J(100), BEQ(1,2,5) back-to-back -> 0x0422000A, 0x00222001, 0x3022000A, 0x34000064, 0x40220005 at addresses 0..4, one per cycle.
- Hold OUT_READY=0 for 3 cycles with IN_VALID=1 -> IN_READY=0 and output stable; release -> no word lost or duplicated.
- MNEM=25 between two legal words -> ERR_ILLEGAL=1 sticky, legal words at consecutive addresses, COUNT excludes the illegal bundle; next START clears ERR_ILLEGAL.
- FINISH after 2 words while the second is stalled -> NOP 0xFC000000 emitted at address 2 after the stall, then DONE=1, COUNT=3, IN_READY=0.
- ADDR_W=2, 5 words -> addresses 0,1,2,3,0; RST asserted mid-stream -> OUT_VALID=0 immediately, IDLE, COUNT=0.

Source files
------------

// File: rtl/instr_encoder.sv
// instr_encoder: packs a mnemonic ID and its register/immediate fields into
// 32-bit ISA words (OP in [31:26], VEC in [0]). Words are streamed to the
// instruction-memory loader at sequential addresses through one output
// register. A NOP terminator is appended when the program ends.
//
// state   | meaning
// IDLE    | after reset, waiting for START
// RUN     | accepting field bundles
// TERM    | FINISH seen, waiting for a free output slot to load the NOP
// DRAIN   | terminator NOP held, waiting for the loader to take it
// DONE_ST | terminator consumed, idle until the next START
module instr_encoder #(
  parameter int ADDR_W    = 10,
  parameter int BASE_ADDR = 0
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              START,
  input  logic              FINISH,
  input  logic              IN_VALID,
  output logic              IN_READY,
  input  logic [4:0]        MNEM,
  input  logic [4:0]        RS,
  input  logic [4:0]        RT,
  input  logic [4:0]        RD,
  input  logic [25:0]       IMM,
  output logic              OUT_VALID,
  input  logic              OUT_READY,
  output logic [31:0]       MEM_WDATA,
  output logic [ADDR_W-1:0] MEM_ADDR,
  output logic [ADDR_W:0]   COUNT,
  output logic              ERR_ILLEGAL,
  output logic              DONE
);

  localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W:0]   CNT_MAX  = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [31:0]       NOP_WORD = 32'hFC00_0000;

  typedef enum logic [2:0] {IDLE, RUN, TERM, DRAIN, DONE_ST} state_t;
  typedef enum logic [1:0] {F_R, F_I, F_J, F_N} fmt_t;

  state_t            state, state_nxt;
  fmt_t              enc_fmt;
  logic [5:0]        enc_op;
  logic              enc_vec;
  logic              enc_legal;
  logic [31:0]       enc_word;
  logic              out_fire;
  logic              load;
  logic [31:0]       load_data;
  logic              clear;
  logic              set_err;
  logic [ADDR_W-1:0] next_addr;

  assign out_fire = OUT_VALID && OUT_READY;
  assign DONE     = (state == DONE_ST);

  // Mnemonic lookup: opcode, word format and vector flag.
  always_comb begin
    enc_op    = 6'b000000;
    enc_fmt   = F_I;
    enc_vec   = 1'b0;
    enc_legal = 1'b1;
    case (MNEM)
      5'd0:  begin enc_op = 6'b000000; enc_fmt = F_R; end
      5'd1:  begin enc_op = 6'b000001; end
      5'd2:  begin enc_op = 6'b000000; enc_fmt = F_R; enc_vec = 1'b1; end
      5'd3:  begin enc_op = 6'b000010; enc_fmt = F_R; end
      5'd4:  begin enc_op = 6'b000011; end
      5'd5:  begin enc_op = 6'b000010; enc_fmt = F_R; enc_vec = 1'b1; end
      5'd6:  begin enc_op = 6'b000100; enc_fmt = F_R; end
      5'd7:  begin enc_op = 6'b000101; end
      5'd8:  begin enc_op = 6'b000100; enc_fmt = F_R; enc_vec = 1'b1; end
      5'd9:  begin enc_op = 6'b000110; enc_fmt = F_R; end
      5'd10: begin enc_op = 6'b000111; end
      5'd11: begin enc_op = 6'b001000; end
      5'd12: begin enc_op = 6'b001001; end
      5'd13: begin enc_op = 6'b001010; end
      5'd14: begin enc_op = 6'b001011; end
      5'd15: begin enc_op = 6'b001100; end
      5'd16: begin enc_op = 6'b001101; enc_fmt = F_J; end
      5'd17: begin enc_op = 6'b010000; end
      5'd18: begin enc_op = 6'b111111; enc_fmt = F_N; end
      default: enc_legal = 1'b0;
    endcase
  end

  // Word assembly by format; fields a format does not use are dropped.
  always_comb begin
    enc_word = 32'h0;
    case (enc_fmt)
      F_R:     enc_word = {enc_op, RS, RT, RD, 10'b0, enc_vec};
      F_I:     enc_word = {enc_op, RS, RT, IMM[15:0]};
      F_J:     enc_word = {enc_op, IMM};
      default: enc_word = {enc_op, 26'b0};
    endcase
  end

  // State register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state, input handshake and output-register load decisions.
  always_comb begin
    state_nxt = state;
    IN_READY  = 1'b0;
    load      = 1'b0;
    load_data = enc_word;
    clear     = 1'b0;
    set_err   = 1'b0;
    case (state)
      IDLE, DONE_ST: begin
        if (START) begin
          state_nxt = RUN;
          clear     = 1'b1;
        end
      end
      RUN: begin
        IN_READY = !FINISH && (!OUT_VALID || OUT_READY);
        if (FINISH) begin
          state_nxt = TERM;
        end else if (IN_VALID && IN_READY) begin
          if (enc_legal) load    = 1'b1;
          else           set_err = 1'b1;
        end
      end
      TERM: begin
        if (!OUT_VALID || OUT_READY) begin
          load      = 1'b1;
          load_data = NOP_WORD;
          state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (out_fire) state_nxt = DONE_ST;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Output register, address allocation, word count and sticky error.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      OUT_VALID   <= 1'b0;
      MEM_WDATA   <= 32'h0;
      MEM_ADDR    <= BASE;
      next_addr   <= BASE;
      COUNT       <= '0;
      ERR_ILLEGAL <= 1'b0;
    end else begin
      if (clear) begin
        MEM_ADDR    <= BASE;
        next_addr   <= BASE;
        COUNT       <= '0;
        ERR_ILLEGAL <= 1'b0;
      end else begin
        if (out_fire && COUNT != CNT_MAX) COUNT <= COUNT + 1'b1;
        if (set_err) ERR_ILLEGAL <= 1'b1;
        if (load) begin
          MEM_WDATA <= load_data;
          MEM_ADDR  <= next_addr;
          next_addr <= next_addr + 1'b1;
        end
      end
      if (load)          OUT_VALID <= 1'b1;
      else if (out_fire) OUT_VALID <= 1'b0;
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder: a default-width instance and a 2-bit-address
// instance share all inputs and are compared every cycle against a
// transaction-level reference built from the ISA encoding table.
module tb_instr_encoder;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        START = 1'b0, FINISH = 1'b0, IN_VALID = 1'b0, OUT_READY = 1'b0;
  logic [4:0]  MNEM = '0, RS = '0, RT = '0, RD = '0;
  logic [25:0] IMM = '0;

  logic        IN_READY, OUT_VALID, ERR_ILLEGAL, DONE;
  logic [31:0] MEM_WDATA;
  logic [9:0]  MEM_ADDR;
  logic [10:0] COUNT;

  logic        s_in_ready, s_out_valid, s_err, s_done;
  logic [31:0] s_wdata;
  logic [1:0]  s_addr;
  logic [2:0]  s_count;

  int n_cmp = 0;
  int n_err = 0;

  // reference state
  int          m_phase;   // 0 idle, 1 run, 2 term, 3 drain, 4 done
  bit          m_occ;
  logic [31:0] m_word;
  bit          m_err;
  int          m_addr[2];
  int          m_nxt[2];
  int          m_cnt[2];
  int          aw[2] = '{10, 2};

  always #5 CLK = ~CLK;

  instr_encoder u_dut (
    .CLK(CLK), .RST(RST), .START(START), .FINISH(FINISH),
    .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .MNEM(MNEM), .RS(RS), .RT(RT), .RD(RD), .IMM(IMM),
    .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
    .MEM_WDATA(MEM_WDATA), .MEM_ADDR(MEM_ADDR), .COUNT(COUNT),
    .ERR_ILLEGAL(ERR_ILLEGAL), .DONE(DONE)
  );

  instr_encoder #(.ADDR_W(2), .BASE_ADDR(0)) u_small (
    .CLK(CLK), .RST(RST), .START(START), .FINISH(FINISH),
    .IN_VALID(IN_VALID), .IN_READY(s_in_ready),
    .MNEM(MNEM), .RS(RS), .RT(RT), .RD(RD), .IMM(IMM),
    .OUT_VALID(s_out_valid), .OUT_READY(OUT_READY),
    .MEM_WDATA(s_wdata), .MEM_ADDR(s_addr), .COUNT(s_count),
    .ERR_ILLEGAL(s_err), .DONE(s_done)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // {legal, word} computed from the ISA table with plain arithmetic
  function automatic logic [32:0] ref_enc(input int m, input int unsigned rs,
                                          input int unsigned rt, input int unsigned rd,
                                          input int unsigned imm);
    int          op_of[19];
    int unsigned op, w;
    op_of = '{0, 1, 0, 2, 3, 2, 4, 5, 4, 6, 7, 8, 9, 10, 11, 12, 13, 16, 63};
    if (m < 0 || m > 18) return {1'b0, 32'h0};
    op = op_of[m];
    if (m inside {0, 2, 3, 5, 6, 8, 9})
      w = (op << 26) | ((rs & 31) << 21) | ((rt & 31) << 16) | ((rd & 31) << 11)
          | ((m inside {2, 5, 8}) ? 1 : 0);
    else if (m == 16) w = (op << 26) | (imm & 32'h03FF_FFFF);
    else if (m == 18) w = op << 26;
    else w = (op << 26) | ((rs & 31) << 21) | ((rt & 31) << 16) | (imm & 32'hFFFF);
    return {1'b1, w};
  endfunction

  task automatic model_reset();
    m_phase = 0; m_occ = 0; m_word = 32'h0; m_err = 0;
    for (int k = 0; k < 2; k++) begin m_addr[k] = 0; m_nxt[k] = 0; m_cnt[k] = 0; end
  endtask

  task automatic model_load(input logic [31:0] w);
    m_occ = 1; m_word = w;
    for (int k = 0; k < 2; k++) begin
      m_addr[k] = m_nxt[k];
      m_nxt[k]  = (m_nxt[k] + 1) % (1 << aw[k]);
    end
  endtask

  // One clock: drive at negedge, check outputs, advance model, wait a cycle.
  task automatic step(input bit iv, input int mn, input int unsigned rs, input int unsigned rt,
                      input int unsigned rd, input int unsigned imm, input bit ordy,
                      input bit st, input bit fin);
    bit          exp_ir, fire, occ_before;
    logic [32:0] e;
    IN_VALID = iv; MNEM = 5'(mn); RS = 5'(rs); RT = 5'(rt); RD = 5'(rd); IMM = 26'(imm);
    OUT_READY = ordy; START = st; FINISH = fin;
    #1;
    exp_ir = (m_phase == 1) && !fin && (!m_occ || ordy);
    check("in_ready", IN_READY, exp_ir);
    check("s_in_ready", s_in_ready, exp_ir);
    check("out_valid", OUT_VALID, m_occ);
    check("s_out_valid", s_out_valid, m_occ);
    if (m_occ) begin
      check("wdata", MEM_WDATA, m_word);
      check("s_wdata", s_wdata, m_word);
      check("addr", MEM_ADDR, m_addr[0]);
      check("s_addr", s_addr, m_addr[1]);
    end
    check("count", COUNT, m_cnt[0]);
    check("s_count", s_count, m_cnt[1]);
    check("err", ERR_ILLEGAL, m_err);
    check("s_err", s_err, m_err);
    check("done", DONE, m_phase == 4);
    check("s_done", s_done, m_phase == 4);

    e = ref_enc(mn, rs, rt, rd, imm);
    occ_before = m_occ;
    fire = m_occ && ordy;
    if (fire) begin
      for (int k = 0; k < 2; k++)
        if (m_cnt[k] < (1 << aw[k])) m_cnt[k]++;
      m_occ = 0;
    end
    case (m_phase)
      0, 4: if (st) begin
        m_phase = 1; m_err = 0;
        for (int k = 0; k < 2; k++) begin m_nxt[k] = 0; m_addr[k] = 0; m_cnt[k] = 0; end
      end
      1: begin
        if (fin) m_phase = 2;
        else if (iv && exp_ir) begin
          if (e[32]) model_load(e[31:0]);
          else m_err = 1;
        end
      end
      2: if (!occ_before || ordy) begin model_load(32'hFC00_0000); m_phase = 3; end
      3: if (fire) m_phase = 4;
      default: ;
    endcase
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic idle_step(input bit ordy);
    step(0, 0, 0, 0, 0, 0, ordy, 0, 0);
  endtask

  logic [31:0] exp_w[5];
  int          sm[5], srs[5], srt[5], srd[5], simm[5];

  initial begin
    model_reset();
    @(negedge CLK); @(negedge CLK);
    #1;
    check("rst_out_valid", OUT_VALID, 1'b0);
    check("rst_wdata", MEM_WDATA, 32'h0);
    check("rst_addr", MEM_ADDR, 10'd0);
    check("rst_count", COUNT, 11'd0);
    check("rst_err", ERR_ILLEGAL, 1'b0);
    check("rst_done", DONE, 1'b0);
    RST = 1'b0;
    @(negedge CLK);

    // ADD r3 = r1 + r2
    step(0, 0, 0, 0, 0, 0, 1, 1, 0);
    step(1, 0, 1, 2, 3, 0, 1, 0, 0);
    check("add_word", MEM_WDATA, 32'h0022_1800);
    check("add_addr", MEM_ADDR, 10'd0);

    // back-to-back stream
    sm   = '{1, 2, 15, 16, 17};
    srs  = '{1, 1, 1, 0, 1};
    srt  = '{2, 2, 2, 0, 2};
    srd  = '{0, 4, 0, 0, 0};
    simm = '{10, 0, 10, 100, 5};
    exp_w = '{32'h0422_000A, 32'h0022_2001, 32'h3022_000A, 32'h3400_0064, 32'h4022_0005};
    for (int i = 0; i < 5; i++) begin
      step(1, sm[i], srs[i], srt[i], srd[i], simm[i], 1, 0, 0);
      check("stream_word", MEM_WDATA, exp_w[i]);
      check("stream_addr", MEM_ADDR, 10'(i + 1));
    end

    // stall with a bundle waiting, then release
    for (int i = 0; i < 3; i++) step(1, 6, 7, 8, 9, 0, 0, 0, 0);
    step(1, 6, 7, 8, 9, 0, 1, 0, 0);
    idle_step(1);
    idle_step(1);

    // illegal mnemonic between two legal words
    step(1, 3, 4, 5, 6, 0, 1, 0, 0);
    step(1, 25, 4, 5, 6, 0, 1, 0, 0);
    step(1, 4, 4, 5, 0, 77, 1, 0, 0);
    idle_step(1);
    check("illegal_sticky", ERR_ILLEGAL, 1'b1);
    step(0, 0, 0, 0, 0, 0, 1, 0, 1);
    idle_step(1);
    idle_step(1);
    idle_step(1);

    // FINISH while the second word is stalled
    step(0, 0, 0, 0, 0, 0, 1, 1, 0);
    check("start_clears_err", ERR_ILLEGAL, 1'b0);
    step(1, 9, 1, 2, 3, 0, 1, 0, 0);
    step(1, 7, 3, 4, 0, 1234, 1, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 1);
    idle_step(0);
    idle_step(0);
    idle_step(1);
    check("nop_word", MEM_WDATA, 32'hFC00_0000);
    check("nop_addr", MEM_ADDR, 10'd2);
    idle_step(1);
    check("fin_count", COUNT, 11'd3);
    check("fin_done", DONE, 1'b1);
    check("fin_in_ready", IN_READY, 1'b0);

    // five words: the 2-bit instance wraps its address and saturates COUNT
    step(0, 0, 0, 0, 0, 0, 1, 1, 0);
    for (int i = 0; i < 5; i++) step(1, 10 + i, i, i + 1, 0, i * 3, 1, 0, 0);
    check("wrap_s_addr", s_addr, 2'd0);
    step(0, 0, 0, 0, 0, 0, 1, 0, 1);
    idle_step(1);
    idle_step(1);
    check("sat_s_count", s_count, 3'd4);
    check("full_count", COUNT, 11'd6);

    // randomized programs
    for (int i = 0; i < 400; i++) begin
      bit iv, ordy, st, fin;
      int mn;
      iv   = ($urandom_range(0, 3) != 0);
      mn   = ($urandom_range(0, 7) == 0) ? int'($urandom_range(19, 31)) : int'($urandom_range(0, 18));
      ordy = ($urandom_range(0, 3) != 0);
      fin  = ($urandom_range(0, 29) == 0);
      st   = (m_phase == 0 || m_phase == 4) ? ($urandom_range(0, 2) == 0)
                                            : ($urandom_range(0, 49) == 0);
      step(iv, mn, $urandom(), $urandom(), $urandom(), $urandom(), ordy, st, fin);
    end
    step(0, 0, 0, 0, 0, 0, 1, 0, 1);
    for (int i = 0; i < 4; i++) idle_step(1);

    // reset in the middle of a stalled stream
    step(0, 0, 0, 0, 0, 0, 1, 1, 0);
    step(1, 8, 1, 2, 3, 0, 0, 0, 0);
    step(1, 8, 1, 2, 3, 0, 0, 0, 0);
    #2 RST = 1'b1;
    #1;
    check("midrst_out_valid", OUT_VALID, 1'b0);
    check("midrst_s_out_valid", s_out_valid, 1'b0);
    check("midrst_count", COUNT, 11'd0);
    check("midrst_done", DONE, 1'b0);
    model_reset();
    @(negedge CLK);
    RST = 1'b0;
    step(1, 0, 1, 2, 3, 0, 1, 0, 0);
    idle_step(1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
